// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - merges i-cache and d-cache line ports onto one physical-memory port
// Grants one requester at a time, latches its request and holds it until mem_resp.
module pmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic [ADDR_W-1:0] i_pmem_address,
   input  logic              i_pmem_read,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,

   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,

   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [LINE_W-1:0] lat_wdata_q;
   logic              lat_wr_q;
   logic              last_d_q;

   logic i_req;
   logic d_req;
   logic grant_d;
   logic grant_i;

   // On a tie the side that did not win last time goes first, so neither starves.
   always_comb begin
      i_req   = i_pmem_read;
      d_req   = d_pmem_read | d_pmem_write;
      grant_d = d_req & (~i_req | ~last_d_q);
      grant_i = i_req & ~grant_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         lat_wr_q    <= 1'b0;
         last_d_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  state_q     <= D_BUSY;
                  lat_addr_q  <= d_pmem_address;
                  lat_wdata_q <= d_pmem_wdata;
                  // read+write together is illegal; treating it as a write keeps dirty data safe
                  lat_wr_q    <= d_pmem_write;
                  last_d_q    <= 1'b1;
               end else if (grant_i) begin
                  state_q    <= I_BUSY;
                  lat_addr_q <= i_pmem_address;
                  lat_wr_q   <= 1'b0;
                  last_d_q   <= 1'b0;
               end
            end
            I_BUSY, D_BUSY: begin
               if (mem_resp) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_address = lat_addr_q;
   assign mem_wdata   = lat_wdata_q;
   assign mem_read    = (state_q == I_BUSY) | ((state_q == D_BUSY) & ~lat_wr_q);
   assign mem_write   = (state_q == D_BUSY) & lat_wr_q;

   // Data is broadcast; only the resp pulse tells a cache the line is its own.
   assign i_pmem_rdata = mem_rdata;
   assign d_pmem_rdata = mem_rdata;
   assign i_pmem_resp  = mem_resp & (state_q == I_BUSY);
   assign d_pmem_resp  = mem_resp & (state_q == D_BUSY);

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed and randomized checks of pmem_arbiter against a transaction model
module tb_pmem_arbiter;
   localparam int AW = 16;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] i_pmem_address = '0;
   logic          i_pmem_read = 1'b0;
   logic [LW-1:0] i_pmem_rdata;
   logic          i_pmem_resp;
   logic [AW-1:0] d_pmem_address = '0;
   logic [LW-1:0] d_pmem_wdata = '0;
   logic          d_pmem_read = 1'b0;
   logic          d_pmem_write = 1'b0;
   logic [LW-1:0] d_pmem_rdata;
   logic          d_pmem_resp;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_wdata;
   logic          mem_read;
   logic          mem_write;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_resp = 1'b0;

   always #5 clk = ~clk;

   pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_pmem_address (i_pmem_address),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transaction-level model: who owns the port (0 none, 1 icache, 2 dcache) and what it asked for.
   int            m_owner;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata;
   logic          m_wr;
   logic          m_last_d;
   logic          seen_i_resp;
   logic          seen_d_resp;
   logic [LW-1:0] seen_i_rdata;
   logic [LW-1:0] seen_d_rdata;

   task automatic model_reset();
      m_owner  = 0;
      m_addr   = '0;
      m_wdata  = '0;
      m_wr     = 1'b0;
      m_last_d = 1'b0;
   endtask

   task automatic model_check();
      check("mem_read",    LW'(mem_read),    LW'((m_owner == 1) || (m_owner == 2 && !m_wr)));
      check("mem_write",   LW'(mem_write),   LW'(m_owner == 2 && m_wr));
      check("mem_address", LW'(mem_address), LW'(m_addr));
      check("mem_wdata",   mem_wdata,        m_wdata);
      check("i_resp",      LW'(i_pmem_resp), LW'(mem_resp && m_owner == 1));
      check("d_resp",      LW'(d_pmem_resp), LW'(mem_resp && m_owner == 2));
      check("i_rdata",     i_pmem_rdata,     mem_rdata);
      check("d_rdata",     d_pmem_rdata,     mem_rdata);
      seen_i_resp  = i_pmem_resp;
      seen_d_resp  = d_pmem_resp;
      seen_i_rdata = i_pmem_rdata;
      seen_d_rdata = d_pmem_rdata;
   endtask

   task automatic model_clock();
      bit ir;
      bit dr;
      int winner;
      if (m_owner != 0) begin
         if (mem_resp) m_owner = 0;
      end else begin
         ir = i_pmem_read;
         dr = d_pmem_read || d_pmem_write;
         if (ir && dr)  winner = m_last_d ? 1 : 2;
         else if (dr)   winner = 2;
         else if (ir)   winner = 1;
         else           winner = 0;
         if (winner == 2) begin
            m_owner  = 2;
            m_addr   = d_pmem_address;
            m_wdata  = d_pmem_wdata;
            m_wr     = d_pmem_write;
            m_last_d = 1'b1;
         end else if (winner == 1) begin
            m_owner  = 1;
            m_addr   = i_pmem_address;
            m_wr     = 1'b0;
            m_last_d = 1'b0;
         end
      end
   endtask

   task automatic step(input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic dw, input logic [AW-1:0] da,
                       input logic [LW-1:0] dwd, input logic mr, input logic [LW-1:0] mrd);
      @(negedge clk);
      i_pmem_read    = ir;
      i_pmem_address = ia;
      d_pmem_read    = dr;
      d_pmem_write   = dw;
      d_pmem_address = da;
      d_pmem_wdata   = dwd;
      mem_resp       = mr;
      mem_rdata      = mrd;
      #1;
      model_check();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mem_write", LW'(mem_write), '0);
      check("rst_mem_read",  LW'(mem_read),  '0);
      check("rst_mem_addr",  LW'(mem_address), '0);
      mem_resp = 1'b1;
      #1;
      check("rst_d_resp", LW'(d_pmem_resp), '0);
      check("rst_i_resp", LW'(i_pmem_resp), '0);
      model_reset();
      i_pmem_read  = 1'b0;
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
      @(negedge clk);
      mem_resp = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      model_clock();
      #1;
   endtask

   function automatic logic [LW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   localparam logic [LW-1:0] LINE_DB = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
   localparam logic [LW-1:0] PAT_A   = 128'hAAAA_5555_AAAA_5555_0123_4567_89AB_CDEF;
   localparam logic [LW-1:0] PAT_B   = 128'h5555_AAAA_5555_AAAA_FEDC_BA98_7654_3210;

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check("reset_mem_read",  LW'(mem_read),  '0);
      check("reset_mem_write", LW'(mem_write), '0);
      check("reset_mem_wdata", mem_wdata,      '0);
      check("reset_i_resp",    LW'(i_pmem_resp), '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) step(0, 16'h0, 0, 0, 16'h0, '0, 0, '0);
      check("idle_no_strobe", LW'(mem_read | mem_write), '0);

      // Instruction read alone
      step(1, 16'h1230, 0, 0, 16'h0, '0, 0, '0);
      check("iread_strobe", LW'(mem_read), 1);
      check("iread_addr",   LW'(mem_address), LW'(16'h1230));
      repeat (2) step(1, 16'h1230, 0, 0, 16'h0, '0, 0, '0);
      step(1, 16'h1230, 0, 0, 16'h0, '0, 1, LINE_DB);
      check("iread_resp",  LW'(seen_i_resp), 1);
      check("iread_rdata", seen_i_rdata, LINE_DB);
      check("iread_dresp", LW'(seen_d_resp), 0);
      step(0, 16'h0, 0, 0, 16'h0, '0, 0, '0);

      // Simultaneous requests from reset: D, then I, then D again
      mid_reset();
      step(1, 16'h0040, 1, 0, 16'h0080, '0, 0, '0);
      check("tie1_addr", LW'(mem_address), LW'(16'h0080));
      check("tie1_read", LW'(mem_read), 1);
      step(1, 16'h0040, 1, 0, 16'h0080, '0, 1, rnd_line());
      check("tie_gap", LW'(mem_read | mem_write), '0);
      step(1, 16'h0040, 1, 0, 16'h0080, '0, 0, '0);
      check("tie2_addr", LW'(mem_address), LW'(16'h0040));
      step(1, 16'h0040, 1, 0, 16'h0080, '0, 1, rnd_line());
      check("tie2_iresp", LW'(seen_i_resp), 1);
      step(1, 16'h0040, 1, 0, 16'h0080, '0, 0, '0);
      check("tie3_addr", LW'(mem_address), LW'(16'h0080));
      step(0, 16'h0, 0, 0, 16'h0, '0, 1, rnd_line());
      check("tie3_dresp", LW'(seen_d_resp), 1);

      // Writeback with wdata changing mid-flight
      step(0, 16'h0, 0, 1, 16'h7F00, PAT_A, 0, '0);
      check("wb_write", LW'(mem_write), 1);
      check("wb_read",  LW'(mem_read), 0);
      step(0, 16'h0, 0, 1, 16'h1111, PAT_B, 0, '0);
      check("wb_hold_data", mem_wdata, PAT_A);
      check("wb_hold_addr", LW'(mem_address), LW'(16'h7F00));
      step(0, 16'h0, 0, 1, 16'h1111, PAT_B, 1, '0);
      check("wb_dresp", LW'(seen_d_resp), 1);
      step(0, 16'h0, 0, 0, 16'h0, '0, 0, '0);

      // Reset during a writeback, then stray resp while idle
      step(0, 16'h0, 0, 1, 16'h2200, PAT_B, 0, '0);
      check("wb2_write", LW'(mem_write), 1);
      mid_reset();
      step(0, 16'h0, 0, 0, 16'h0, '0, 1, rnd_line());
      check("stray_i", LW'(seen_i_resp), 0);
      check("stray_d", LW'(seen_d_resp), 0);

      // Illegal read+write together is a write
      step(0, 16'h0, 1, 1, 16'h3300, PAT_A, 0, '0);
      check("rw_write", LW'(mem_write), 1);
      check("rw_read",  LW'(mem_read), 0);
      step(0, 16'h0, 0, 0, 16'h0, '0, 1, '0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 1) == 0, 16'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 16'($urandom),
              rnd_line(), $urandom_range(0, 2) == 0, rnd_line());
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end
endmodule
